// File: rtl/string_accel_avalon.sv
// string_accel_avalon: Avalon-MM string accelerator running byte-wise ops over an on-chip word buffer.
// Optional feature: define STRING_ACCEL_IRQ_EN to add the irq output and the CTRL[4] irq_en bit.
module string_accel_avalon #(
    parameter int BUF_WORDS = 16,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata
`ifdef STRING_ACCEL_IRQ_EN
    ,
    output logic              irq
`endif
);
    localparam int WW = $clog2(BUF_WORDS);
    localparam logic [2:0] OP_UPPER   = 3'd0;
    localparam logic [2:0] OP_LOWER   = 3'd1;
    localparam logic [2:0] OP_STRLEN  = 3'd2;
    localparam logic [2:0] OP_FIND    = 3'd3;
    localparam logic [2:0] OP_COUNT   = 3'd4;
    localparam logic [2:0] OP_REPLACE = 3'd5;

    typedef enum logic [1:0] {IDLE, FETCH, PROC, DONE} state_t;

    state_t        r_state;
    logic [2:0]    r_op;
    logic          r_irq_en;
    logic [15:0]   r_len;
    logic [15:0]   r_arg;
    logic [31:0]   r_result;
    logic [31:0]   r_word_data;
    logic [WW-1:0] r_word;
    logic          r_done;
    logic          r_len_err;
    logic          r_busy_wr;
    logic [31:0]   r_buf [BUF_WORDS];

    logic          w_wr;
    logic          w_rd;
    logic          w_busy;
    logic          w_buf_sel;
    logic [WW-1:0] w_buf_idx;
    logic          w_go;
    logic          w_wr_ign;
    logic          w_done_w1c;
    logic          w_last;
    logic          w_early;
    logic [31:0]   w_rdmux;
    logic [31:0]   w_new;
    logic [31:0]   w_hit_cnt;
    logic [3:0]    w_hit;
    logic [15:0]   w_hit_idx;
    logic [15:0]   w_k;
    logic [7:0]    w_byte;
    logic [7:0]    w_nb;
    logic          w_in;

    assign w_wr       = chipselect & write;
    assign w_rd       = chipselect & read;
    assign w_busy     = (r_state == FETCH) || (r_state == PROC);
    assign w_buf_sel  = (32'(address) >= 32'd8) && (32'(address) < 32'(8 + BUF_WORDS));
    assign w_buf_idx  = WW'(address - ADDR_W'(8));
    assign w_go       = w_wr && !w_busy && address == ADDR_W'(0) && writedata[0];
    assign w_wr_ign   = w_wr && w_busy && (address == ADDR_W'(0) || address == ADDR_W'(2) ||
                                           address == ADDR_W'(3) || w_buf_sel);
    assign w_done_w1c = w_wr && address == ADDR_W'(1) && writedata[1];
    assign w_last     = 16'(r_word) == ((r_len - 16'd1) >> 2);
    assign w_early    = (r_op == OP_STRLEN || r_op == OP_FIND) && (|w_hit);

    assign w_rdmux = w_buf_sel ? (w_busy ? 32'd0 : r_buf[w_buf_idx]) :
                     address == ADDR_W'(0) ? {27'd0, r_irq_en, r_op, 1'b0} :
                     address == ADDR_W'(1) ? {28'd0, r_busy_wr, r_len_err, r_done, w_busy} :
                     address == ADDR_W'(2) ? {16'd0, r_len} :
                     address == ADDR_W'(3) ? {16'd0, r_arg} :
                     address == ADDR_W'(4) ? r_result : 32'd0;

    // Evaluate all four lanes of the fetched word: transformed bytes, match flags, count and first hit
    always_comb begin
        w_new     = r_word_data;
        w_hit     = '0;
        w_hit_cnt = '0;
        w_hit_idx = '0;
        w_k       = '0;
        w_byte    = '0;
        w_nb      = '0;
        w_in      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_k       = 16'({r_word, 2'(i)});
            w_in      = w_k < r_len;
            w_byte    = r_word_data[31-8*i -: 8];
            w_hit[i]  = w_in && (r_op == OP_STRLEN ? w_byte == 8'h00 : w_byte == r_arg[7:0]);
            w_nb      = !w_in ? w_byte :
                        (r_op == OP_UPPER && w_byte >= 8'h61 && w_byte <= 8'h7a) ? w_byte - 8'h20 :
                        (r_op == OP_LOWER && w_byte >= 8'h41 && w_byte <= 8'h5a) ? w_byte + 8'h20 :
                        (r_op == OP_REPLACE && w_hit[i]) ? r_arg[15:8] : w_byte;
            w_new[31-8*i -: 8] = w_nb;
            w_hit_cnt = w_hit_cnt + 32'(w_hit[i]);
        end
        for (int i = 3; i >= 0; i--) begin
            if (w_hit[i]) w_hit_idx = 16'({r_word, 2'(i)});
        end
    end

    // Register file, bus read data and the IDLE/FETCH/PROC/DONE engine
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_irq_en    <= 1'b0;
            r_len       <= '0;
            r_arg       <= '0;
            r_result    <= '0;
            r_word_data <= '0;
            r_word      <= '0;
            r_done      <= 1'b0;
            r_len_err   <= 1'b0;
            r_busy_wr   <= 1'b0;
            readdata    <= '0;
        end else begin
            if (w_rd) readdata <= w_wr ? writedata : w_rdmux;
            if (w_wr && !w_busy && address == ADDR_W'(0)) begin
                r_op <= writedata[3:1];
`ifdef STRING_ACCEL_IRQ_EN
                r_irq_en <= writedata[4];
`endif
            end
            if (w_wr && !w_busy && address == ADDR_W'(2)) r_len <= writedata[15:0];
            if (w_wr && !w_busy && address == ADDR_W'(3)) r_arg <= writedata[15:0];
            if (w_done_w1c) r_done <= 1'b0;
            if (w_wr && address == ADDR_W'(1) && writedata[3]) r_busy_wr <= 1'b0;
            if (w_wr_ign) r_busy_wr <= 1'b1;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    if (w_go) begin
                        r_result  <= '0;
                        r_len_err <= 1'b0;
                        r_word    <= '0;
                        if (writedata[3:1] > OP_REPLACE || r_len > 16'(4 * BUF_WORDS)) begin
                            r_len_err <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= DONE;
                        end else if (r_len == 16'd0) begin
                            r_result <= writedata[3:1] == OP_FIND ? '1 : '0;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    r_word_data <= r_buf[r_word];
                    r_state     <= PROC;
                end
                PROC: begin
                    r_result <= w_early ? 32'(w_hit_idx) :
                                (w_last && r_op == OP_STRLEN) ? 32'(r_len) :
                                (w_last && r_op == OP_FIND) ? '1 :
                                (r_op == OP_COUNT || r_op == OP_REPLACE) ? r_result + w_hit_cnt : r_result;
                    r_word   <= r_word + WW'(1);
                    r_state  <= (w_early || w_last) ? DONE : FETCH;
                    if (w_early || w_last) r_done <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Buffer storage: engine write-back while processing, bus writes otherwise; contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && r_state == PROC) r_buf[r_word] <= w_new;
        else if (!reset && w_wr && !w_busy && w_buf_sel) r_buf[w_buf_idx] <= writedata;
    end

`ifdef STRING_ACCEL_IRQ_EN
    // Interrupt follows done one cycle later and drops together with the done clear
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else irq <= r_done & r_irq_en & ~w_done_w1c;
    end
`endif
endmodule

// File: tb/tb_string_accel_avalon.sv
// tb_string_accel_avalon: randomized and directed bench for string_accel_avalon against a byte-level model.
module tb_string_accel_avalon;
    localparam int BW = 16;
    localparam int NB = 4 * BW;
`ifdef STRING_ACCEL_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
`ifdef STRING_ACCEL_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    string_accel_avalon #(.BUF_WORDS(BW), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata)
`ifdef STRING_ACCEL_IRQ_EN
        , .irq(irq)
`endif
    );

    logic [7:0]  m_mem [NB];
    logic [15:0] m_len, m_arg;
    logic [2:0]  m_op;
    logic        m_irq_en, m_done, m_len_err, m_busy_wr, m_irq, m_rd_dc;
    logic        check_en = 1'b0;
    logic [31:0] m_result, m_final, m_rd;
    int          cyc = 0;
    int          m_go = -10;
    int          m_tdone = -10;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_word(input int w);
        return {m_mem[4*w], m_mem[4*w+1], m_mem[4*w+2], m_mem[4*w+3]};
    endfunction

    function automatic logic [31:0] m_read(input int a, input logic busy);
        if (a >= 8 && a < 8 + BW) return busy ? 32'd0 : m_word(a - 8);
        case (a)
            0: return {27'd0, m_irq_en, m_op, 1'b0};
            1: return {28'd0, m_busy_wr, m_len_err, m_done, busy};
            2: return {16'd0, m_len};
            3: return {16'd0, m_arg};
            4: return m_result;
            default: return 32'd0;
        endcase
    endfunction

    // Whole operation computed at go: final buffer, final result and the cycle done appears
    task automatic m_start(input logic [2:0] op);
        int last;
        logic [7:0] b;
        last = int'(m_len) - 1;
        m_len_err = 1'b0;
        m_result = '0;
        m_final = '0;
        m_go = cyc;
        if (op > 3'd5 || int'(m_len) > NB) begin
            m_len_err = 1'b1;
            m_tdone = cyc + 1;
        end else if (m_len == 16'd0) begin
            m_tdone = cyc + 1;
            if (op == 3'd3) m_final = '1;
        end else begin
            if (op == 3'd2) m_final = 32'(m_len);
            if (op == 3'd3) m_final = '1;
            for (int k = 0; k < int'(m_len); k++) begin
                b = m_mem[k];
                if (op == 3'd0 && b >= 8'h61 && b <= 8'h7a) m_mem[k] = b - 8'd32;
                if (op == 3'd1 && b >= 8'h41 && b <= 8'h5a) m_mem[k] = b + 8'd32;
                if ((op == 3'd4 || op == 3'd5) && b == m_arg[7:0]) begin
                    m_final = m_final + 32'd1;
                    if (op == 3'd5) m_mem[k] = m_arg[15:8];
                end
                if ((op == 3'd2 && b == 8'h00) || (op == 3'd3 && b == m_arg[7:0])) begin
                    m_final = 32'(k);
                    last = k;
                    break;
                end
            end
            m_tdone = cyc + 1 + 2 * (last / 4 + 1);
        end
    endtask

    // Model state advances on each active edge from the bus inputs of the cycle just ended
    always @(posedge clk) begin
        logic busy;
        busy = cyc > m_go && cyc < m_tdone;
        if (reset) begin
            m_len = '0; m_arg = '0; m_op = '0; m_irq_en = 1'b0; m_done = 1'b0; m_len_err = 1'b0;
            m_busy_wr = 1'b0; m_irq = 1'b0; m_result = '0; m_rd = '0; m_rd_dc = 1'b0;
            m_go = -10; m_tdone = -10;
        end else begin
            m_irq = m_irq_en && m_done && !(chipselect && write && address == 5'd1 && writedata[1]);
            if (chipselect && read) begin
                m_rd = write ? writedata : m_read(int'(address), busy);
                m_rd_dc = !write && address == 5'd4 && busy;
            end
            if (chipselect && write) begin
                case (int'(address))
                    0: if (busy) m_busy_wr = 1'b1;
                       else begin
                           m_op = writedata[3:1];
                           m_irq_en = IRQ && writedata[4];
                           if (writedata[0]) m_start(writedata[3:1]);
                       end
                    1: begin
                           if (writedata[1]) m_done = 1'b0;
                           if (writedata[3]) m_busy_wr = 1'b0;
                       end
                    2: if (busy) m_busy_wr = 1'b1; else m_len = writedata[15:0];
                    3: if (busy) m_busy_wr = 1'b1; else m_arg = writedata[15:0];
                    default: if (address >= 5'd8 && int'(address) < 8 + BW) begin
                        if (busy) m_busy_wr = 1'b1;
                        else for (int l = 0; l < 4; l++) m_mem[4*(int'(address)-8)+l] = writedata[31-8*l -: 8];
                    end
                endcase
            end
            if (cyc + 1 == m_tdone) begin
                m_done = 1'b1;
                m_result = m_final;
            end
        end
        cyc++;
    end

    // Every cycle: readdata must hold the last read's value, irq must follow the model
    always @(negedge clk) begin
        if (check_en) begin
            if (!m_rd_dc) check("readdata", readdata, m_rd);
`ifdef STRING_ACCEL_IRQ_EN
            check("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
        end
    end

    task automatic wr(input int a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; read = 1'b0; address = 5'(a); writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 5'(a);
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic rd_chk(input string n, input int a, input logic [31:0] e);
        logic [31:0] d;
        rd(a, d);
        check(n, d, e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done();
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 200; i++) begin
            rd(1, s);
            if (s[1]) return;
        end
        check("done_timeout", s, 32'h2);
    endtask

    function automatic logic [7:0] rnd_char();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h61;
            2: return 8'h62;
            3: return 8'h41;
            4: return 8'h42;
            5: return 8'h7a;
            6: return 8'h5a;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic rnd_access();
        logic [31:0] d;
        case ($urandom_range(0, 4))
            0: rd($urandom_range(0, 31), d);
            1: wr(2, $urandom_range(0, 70));
            2: wr(3, {16'd0, rnd_char(), rnd_char()});
            3: wr($urandom_range(8, 8 + BW - 1), {rnd_char(), rnd_char(), rnd_char(), rnd_char()});
            default: wr(0, {28'd0, 3'($urandom_range(0, 5)), 1'($urandom_range(0, 1))});
        endcase
    endtask

    initial begin
        logic [31:0] d;
        logic [2:0] op;
        int r;
        reset = 1'b1;
        @(posedge clk); #1;
        check_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rd_chk("rst_status", 1, 0);
        rd_chk("rst_len", 2, 0);
        rd_chk("rst_result", 4, 0);
        rd_chk("rst_ctrl", 0, 0);
        for (int w = 0; w < BW; w++) wr(8 + w, 0);
        rd_chk("reserved", 6, 0);

        wr(8, 32'h61624344); wr(2, 4); wr(0, 32'h1);
        rd_chk("upper_busy1", 1, 1);
        rd_chk("upper_busy2", 1, 1);
        rd_chk("upper_done", 1, 2);
        rd_chk("upper_buf", 8, 32'h41424344);
        rd_chk("upper_result", 4, 0);
        wr(1, 32'hA);

        wr(8, 32'h68656C6C); wr(9, 32'h6F20776F); wr(2, 8); wr(3, 32'h6F); wr(0, 32'h7);
        rd(1, d); rd(1, d); rd(1, d);
        rd_chk("find_busy", 1, 1);
        rd_chk("find_done", 1, 2);
        rd_chk("find_result", 4, 4);
        wr(1, 32'hA);

        wr(8, 32'h61586158); wr(9, 32'h61616161); wr(2, 5); wr(3, 32'h4261); wr(0, 32'hB);
        wait_done();
        rd_chk("repl_w0", 8, 32'h42584258);
        rd_chk("repl_w1", 9, 32'h42616161);
        rd_chk("repl_result", 4, 3);
        wr(1, 32'hA);

        wr(2, NB + 1); wr(0, 32'h1);
        rd_chk("lenerr_status", 1, 6);
        rd_chk("lenerr_buf", 8, 32'h42584258);
        wr(1, 32'hA);
        wr(2, 4); wr(0, 32'hD);
        rd_chk("op6_status", 1, 6);
        rd_chk("op6_result", 4, 0);
        wr(1, 32'hA);

        wr(2, NB); wr(3, 32'h61); wr(0, 32'h9); wr(2, 3);
        rd_chk("busywr_status", 1, 9);
        wait_done();
        rd_chk("count_result", 4, 3);
        rd_chk("busywr_len", 2, NB);
        wr(1, 32'hA);
        rd_chk("busywr_clr", 1, 0);

        wr(0, 32'h9); idle(5); rd(2, d);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_rd", readdata, 0);
        rd_chk("rst_mid_status", 1, 0);
        rd_chk("rst_mid_result", 4, 0);
        wr(2, NB); wr(3, 32'h61); wr(0, 32'h9);
        wait_done();
        rd_chk("rst_count", 4, 3);
        wr(1, 32'hA);

        wr(0, 32'h10);
        rd_chk("ctrl_irqen", 0, IRQ ? 32'h10 : 32'h0);
`ifdef STRING_ACCEL_IRQ_EN
        wr(2, 4); wr(0, 32'h13);
        idle(2);
        check("irq_at_done", {31'd0, irq}, 0);
        idle(1);
        check("irq_after_done", {31'd0, irq}, 1);
        wr(1, 32'h2);
        check("irq_clear", {31'd0, irq}, 0);
`endif
        wr(0, 32'h0);

        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < BW; w++) wr(8 + w, {rnd_char(), rnd_char(), rnd_char(), rnd_char()});
            r = $urandom_range(0, 19);
            wr(2, r == 0 ? 0 : r == 1 ? $urandom_range(NB + 1, NB + 4) : $urandom_range(1, NB));
            wr(3, {16'd0, rnd_char(), rnd_char()});
            op = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
            wr(0, {28'd0, op, 1'b1});
            repeat ($urandom_range(0, 6)) rnd_access();
            wait_done();
            rd(4, d); rd(2, d); rd(0, d); rd(1, d);
            for (int w = 0; w < BW; w++) rd(8 + w, d);
            wr(1, 32'hA);
        end

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
